// File: rtl/infifo_dispatcher_pkg.sv
// Shared types and constants for the input-FIFO packet dispatcher.
package infifo_dispatcher_pkg;

    localparam int THREAD_SEL_W = 3;
    localparam logic [7:0] PKT_WORDS_MAX = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_FIRST,
        ST_BODY,
        ST_HEADER_TAIL,
        ST_RELEASE
    } disp_state_t;

    function automatic logic is_pop_state(input disp_state_t s);
        return (s == ST_FIRST) || (s == ST_BODY) || (s == ST_HEADER_TAIL);
    endfunction

endpackage

// File: rtl/dispatch_thread_ptr.sv
// Round-robin destination thread pointer; steps on packet release or on a busy skip.
module dispatch_thread_ptr
    import infifo_dispatcher_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    advance,
    input  logic                    skip_busy,
    output logic [THREAD_SEL_W-1:0] thread_sel
);

    localparam logic [THREAD_SEL_W-1:0] SEL_ONE = 1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            thread_sel <= '0;
        end else if (advance || skip_busy) begin
            thread_sel <= thread_sel + SEL_ONE;
        end
    end

endmodule

// File: rtl/infifo_dispatcher.sv
// Drains packets from the small input FIFO and dispatches each to one thread, round-robin.
// Build option DISPATCH_SKIP_BUSY_EN: SELECT skips busy threads instead of waiting on them.
//
// state        | meaning
// IDLE         | waiting for a word at the FIFO head
// SELECT       | checking the selected thread is free
// FIRST        | popping the first word of a packet
// HEADER_TAIL  | popping header/control words until payload begins
// BODY         | popping payload until the EOP (nonzero ctrl) word
// RELEASE      | one cycle: hand packet to the CPU, latch word count
module infifo_dispatcher
    import infifo_dispatcher_pkg::*;
#(
    parameter int NUM_THREADS = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [CTRL_WIDTH-1:0]   in_ctrl,
    input  logic                    in_empty,
    output logic                    in_rd_en,
    input  logic [NUM_THREADS-1:0]  thread_busy,
    input  logic                    stop_smallfifo_read,
    output logic [THREAD_SEL_W-1:0] thread_sel,
    output logic                    firstword,
    output logic                    fifowrite,
    output logic                    enable_cpu,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [CTRL_WIDTH-1:0]   out_ctrl,
    output logic [7:0]              pkt_words
);

    disp_state_t state, state_nxt;
    logic        pop;
    logic        skip_busy;
    logic [7:0]  word_cnt;

    assign pop      = is_pop_state(state) && !in_empty && !stop_smallfifo_read;
    assign in_rd_en = pop;

    // Pointer advances the cycle after the enable_cpu pulse so the release
    // strobe still targets the packet's own thread.
    dispatch_thread_ptr u_thread_ptr (
        .clk        (clk),
        .reset_n    (reset_n),
        .advance    (enable_cpu),
        .skip_busy  (skip_busy),
        .thread_sel (thread_sel)
    );

    always_comb begin
        state_nxt = state;
        skip_busy = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!in_empty) state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                if (!thread_busy[thread_sel]) begin
                    state_nxt = ST_FIRST;
                end else begin
`ifdef DISPATCH_SKIP_BUSY_EN
                    skip_busy = 1'b1;
`endif
                end
            end
            ST_FIRST: begin
                if (pop) state_nxt = (in_ctrl != '0) ? ST_HEADER_TAIL : ST_BODY;
            end
            ST_HEADER_TAIL: begin
                if (pop && (in_ctrl == '0)) state_nxt = ST_BODY;
            end
            ST_BODY: begin
                if (pop && (in_ctrl != '0)) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            fifowrite  <= 1'b0;
            firstword  <= 1'b0;
            enable_cpu <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            word_cnt   <= '0;
            pkt_words  <= '0;
        end else begin
            state      <= state_nxt;
            fifowrite  <= pop;
            firstword  <= pop && (state == ST_FIRST);
            enable_cpu <= (state == ST_RELEASE);
            if (pop) begin
                out_data <= in_data;
                out_ctrl <= in_ctrl;
            end
            if (state == ST_RELEASE) begin
                pkt_words <= word_cnt;
                word_cnt  <= '0;
            end else if (pop && (word_cnt != PKT_WORDS_MAX)) begin
                word_cnt <= word_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_infifo_dispatcher.sv
// Directed, scoreboard-checked bench for infifo_dispatcher (honours DISPATCH_SKIP_BUSY_EN).
module tb_infifo_dispatcher;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic        f;
        logic [2:0]  t;
    } word_t;

    typedef struct {
        logic [2:0] t;
        logic [7:0] n;
    } rel_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_empty = 1'b1;
    logic        in_rd_en;
    logic [7:0]  thread_busy = '0;
    logic        stop_smallfifo_read = 1'b0;
    logic [2:0]  thread_sel;
    logic        firstword, fifowrite, enable_cpu;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [7:0]  pkt_words;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    last_wr = 0;
    int    wr_cnt = 0;
    logic  prev_en = 1'b0;
    logic [2:0] prev_sel = '0;
    logic  stall = 1'b0;
    logic  popped;
    logic [2:0] exp_thread = '0;
    logic [2:0] pkt_thread;
    int    base;

    word_t fq[$];
    word_t pend[$];
    word_t sb[$];
    rel_t  rel[$];

    infifo_dispatcher dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .in_data             (in_data),
        .in_ctrl             (in_ctrl),
        .in_empty            (in_empty),
        .in_rd_en            (in_rd_en),
        .thread_busy         (thread_busy),
        .stop_smallfifo_read (stop_smallfifo_read),
        .thread_sel          (thread_sel),
        .firstword           (firstword),
        .fifowrite           (fifowrite),
        .enable_cpu          (enable_cpu),
        .out_data            (out_data),
        .out_ctrl            (out_ctrl),
        .pkt_words           (pkt_words)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Small first-word-fall-through FIFO model; head refreshed just after each edge.
    always @(posedge clk) begin
        popped = in_rd_en;
        #1;
        if (popped && fq.size() > 0) fq.delete(0);
        in_empty = stall || (fq.size() == 0);
        in_data  = (fq.size() > 0) ? fq[0].d : 64'd0;
        in_ctrl  = (fq.size() > 0) ? fq[0].c : 8'd0;
    end

    // Packet: nhdr header words (ctrl FF), payload (ctrl 0), EOP (ctrl 01).
    // Words from index split onward are held back until feed_pend().
    task automatic push_pkt(input int len, input int nhdr, input int split);
        word_t w;
        rel_t  r;
        for (int i = 0; i < len; i++) begin
            w.d = {$urandom, $urandom};
            w.c = (i < nhdr) ? 8'hFF : ((i == len - 1) ? 8'h01 : 8'h00);
            w.f = (i == 0);
            w.t = exp_thread;
            sb.push_back(w);
            if (i < split) fq.push_back(w);
            else pend.push_back(w);
        end
        r.t = exp_thread;
        r.n = (len > 255) ? 8'd255 : 8'(len);
        rel.push_back(r);
        exp_thread = exp_thread + 3'd1;
    endtask

    task automatic feed_pend();
        while (pend.size() > 0) begin
            fq.push_back(pend[0]);
            pend.delete(0);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && (sb.size() > 0 || rel.size() > 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check(tag, 64'(sb.size() + rel.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            word_t e;
            rel_t  r;
            cyc++;
            if (fifowrite) begin
                if (sb.size() == 0) begin
                    check("wr_unexpected", fifowrite, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("wr_data", out_data, e.d);
                    check("wr_ctrl", out_ctrl, e.c);
                    check("wr_first", firstword, e.f);
                    check("wr_thread", thread_sel, e.t);
                end
                last_wr = cyc;
                wr_cnt++;
            end else begin
                check("first_without_wr", firstword, 1'b0);
            end
            if (enable_cpu) begin
                if (rel.size() == 0) begin
                    check("en_unexpected", enable_cpu, 1'b0);
                end else begin
                    r = rel.pop_front();
                    check("en_thread", thread_sel, r.t);
                    check("en_pkt_words", pkt_words, r.n);
                    check("en_gap", 64'(cyc - last_wr), 64'd1);
                end
            end
            if (prev_en) check("sel_advance", thread_sel, 3'(prev_sel + 3'd1));
            prev_en  = enable_cpu;
            prev_sel = thread_sel;
        end else begin
            prev_en = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_fifowrite", fifowrite, 1'b0);
        check("rst_firstword", firstword, 1'b0);
        check("rst_enable", enable_cpu, 1'b0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", out_ctrl, 8'd0);
        check("rst_thread_sel", thread_sel, 3'd0);
        check("rst_pkt_words", pkt_words, 8'd0);
        check("rst_rd_en", in_rd_en, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single 4-word packet to thread 0
        push_pkt(4, 1, 4);
        wait_drain("drain_single", 40);
        check("single_pkt_words", pkt_words, 8'd4);
        check("single_next_sel", thread_sel, 3'd1);

        // Eight more back-to-back packets: threads 1..7 then wrap to 0
        for (int p = 0; p < 8; p++) push_pkt(3 + (p % 4), 1 + (p % 2), 64);
        wait_drain("drain_b2b", 200);
        check("wrap_sel", thread_sel, 3'd1);

        // FIFO runs dry mid-packet, then stop_smallfifo_read (alone and with empty)
        base = wr_cnt;
        pkt_thread = exp_thread;
        push_pkt(6, 1, 3);
        for (int i = 0; i < 30 && wr_cnt < base + 3; i++) @(negedge clk);
        check("stall_pre_words", 64'(wr_cnt - base), 64'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_wr", fifowrite, 1'b0);
            check("stall_sel", thread_sel, pkt_thread);
        end
        feed_pend();
        stop_smallfifo_read = 1'b1;
        stall = 1'b1;
        @(negedge clk);
        check("stop_empty_rd", in_rd_en, 1'b0);
        stall = 1'b0;
        @(negedge clk);
        check("stop_rd", in_rd_en, 1'b0);
        check("stop_wr", fifowrite, 1'b0);
        stop_smallfifo_read = 1'b0;
        wait_drain("drain_stall", 40);

        // Thread 2 busy when selected
        thread_busy[2] = 1'b1;
`ifdef DISPATCH_SKIP_BUSY_EN
        exp_thread = 3'd3;
        push_pkt(4, 1, 4);
        wait_drain("drain_skip", 40);
        thread_busy[2] = 1'b0;
`else
        push_pkt(4, 1, 4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("busy_rd", in_rd_en, 1'b0);
            check("busy_sel", thread_sel, 3'd2);
        end
        thread_busy[2] = 1'b0;
        wait_drain("drain_busy", 40);
`endif

        // Reset partway through a packet
        base = wr_cnt;
        push_pkt(8, 1, 8);
        for (int i = 0; i < 30 && wr_cnt < base + 2; i++) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mrst_fifowrite", fifowrite, 1'b0);
        check("mrst_firstword", firstword, 1'b0);
        check("mrst_enable", enable_cpu, 1'b0);
        check("mrst_out_data", out_data, 64'd0);
        check("mrst_out_ctrl", out_ctrl, 8'd0);
        check("mrst_thread_sel", thread_sel, 3'd0);
        check("mrst_pkt_words", pkt_words, 8'd0);
        fq.delete();
        sb.delete();
        rel.delete();
        exp_thread = '0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mrst_no_enable", enable_cpu, 1'b0);
        end

        // 300-word packet: count saturates
        push_pkt(300, 1, 300);
        wait_drain("drain_long", 400);
        check("long_pkt_words", pkt_words, 8'd255);
        check("long_next_sel", thread_sel, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
